// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage core: Execute-stage forwarding,
// load-use detection, branch flushes and a timed wait sequencer for data-memory accesses.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] MT = CW'(MEM_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             mem_err_reg, mem_err_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             mem_stall, lw_stall;

    logic [REG_W-1:0] rs_e [2];
    logic [1:0]       fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // Memory-stage match wins over Writeback: it holds the younger result.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = (RegWriteM && RdM == rs_e[gi] && rs_e[gi] != '0) ? 2'b10 :
                             (RegWriteW && RdW == rs_e[gi] && rs_e[gi] != '0) ? 2'b01 :
                                                                                2'b00;
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    assign lw_stall = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mem_err_next = mem_err_reg;
        mem_stall    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                mem_stall = MemReqM && !MemAckM;
                if (mem_stall) begin
                    state_next = S_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            S_WAIT: begin
                mem_stall = MemReqM && !MemAckM && (cnt_reg < MT);
                // A dropped request ends the access just like an ack does.
                if (!MemReqM || MemAckM) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == MT) begin
                    mem_err_next = 1'b1;
                    state_next   = S_IDLE;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // While reset is held the sequencer must not stall the pipeline, even with a request pending.
    always_comb begin
        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
        FlushW = 1'b0;
        if (mem_stall && CLR_N) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mem_err_reg <= mem_err_next;
            if (StallF && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign MemErr      = mem_err_reg;
    assign StallCycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             CLR_N;
    logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CNT_W-1:0] StallCycles;
    logic [6:0]       ctl;

    int passes = 0;
    int total  = 0;

    assign ctl = {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE};

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCycles(StallCycles)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MemReqM = 0; MemAckM = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        CLR_N = 1'b0;
        #2;
        total++;
        if ({ForwardAE, ForwardBE, ctl, MemErr, StallCycles} !== '0) begin
            $display("FAIL reset_outputs: got fa=%b fb=%b ctl=%b err=%b sc=%0d, want all 0",
                     ForwardAE, ForwardBE, ctl, MemErr, StallCycles);
        end else passes++;
        step();
        CLR_N = 1'b1;
        #1;
        total++;
        if ({ctl, MemErr, StallCycles} !== '0) begin
            $display("FAIL reset_release: got ctl=%b err=%b sc=%0d, want 0", ctl, MemErr, StallCycles);
        end else passes++;
        $display("reset: ctl=%b err=%b sc=%0d", ctl, MemErr, StallCycles);
    endtask

    task automatic test_forwarding();
        RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
        #1;
        total++;
        if (ForwardAE !== 2'b10) $display("FAIL fwdA_mem: got %b want 10", ForwardAE); else passes++;
        total++;
        if (ForwardBE !== 2'b10) $display("FAIL fwdB_mem: got %b want 10", ForwardBE); else passes++;
        RegWriteM = 0;
        #1;
        total++;
        if (ForwardAE !== 2'b01) $display("FAIL fwdA_wb: got %b want 01", ForwardAE); else passes++;
        total++;
        if (ForwardBE !== 2'b01) $display("FAIL fwdB_wb: got %b want 01", ForwardBE); else passes++;
        Rs1E = 0;
        #1;
        total++;
        if (ForwardAE !== 2'b00) $display("FAIL fwdA_zero: got %b want 00", ForwardAE); else passes++;
        total++;
        if (ForwardBE !== 2'b01) $display("FAIL fwdB_indep: got %b want 01", ForwardBE); else passes++;
        Rs2E = 0;
        #1;
        total++;
        if (ForwardBE !== 2'b00) $display("FAIL fwdB_zero: got %b want 00", ForwardBE); else passes++;
        // Writeback off, Memory on for a different register on port B only.
        Rs1E = 7; Rs2E = 9; RdM = 9; RegWriteM = 1; RegWriteW = 0;
        #1;
        total++;
        if ({ForwardAE, ForwardBE} !== 4'b0010) begin
            $display("FAIL fwd_mixed: got %b%b want 0010", ForwardAE, ForwardBE);
        end else passes++;
        $display("forwarding: fa=%b fb=%b", ForwardAE, ForwardBE);
        clear_inputs();
    endtask

    task automatic test_load_use();
        LoadE = 1; RdE = 3; Rs2D = 3;
        #1;
        total++;
        if (ctl !== 7'b1100001) $display("FAIL lw_stall: got ctl=%b want 1100001", ctl); else passes++;
        step();
        total++;
        if (StallCycles !== 16'd1) $display("FAIL lw_count1: got %0d want 1", StallCycles); else passes++;
        step();
        total++;
        if (StallCycles !== 16'd2) $display("FAIL lw_count2: got %0d want 2", StallCycles); else passes++;
        RdE = 0;
        #1;
        total++;
        if (ctl !== 7'b0000000) $display("FAIL lw_rd0: got ctl=%b want 0000000", ctl); else passes++;
        step();
        total++;
        if (StallCycles !== 16'd2) $display("FAIL lw_count_hold: got %0d want 2", StallCycles); else passes++;
        $display("load_use: ctl=%b sc=%0d", ctl, StallCycles);
        clear_inputs();
    endtask

    task automatic test_branch();
        PCSrcE = 1;
        #1;
        total++;
        if (ctl !== 7'b0000011) $display("FAIL branch_only: got ctl=%b want 0000011", ctl); else passes++;
        LoadE = 1; RdE = 3; Rs1D = 3;
        #1;
        total++;
        if (ctl !== 7'b1100011) $display("FAIL branch_lw: got ctl=%b want 1100011", ctl); else passes++;
        $display("branch: ctl=%b", ctl);
        clear_inputs();
        #1;
    endtask

    task automatic test_mem_wait();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== 7'b1111100) $display("FAIL memwait_stall%0d: got ctl=%b want 1111100", i, ctl);
            else passes++;
            step();
        end
        MemAckM = 1;
        #1;
        total++;
        if (ctl !== 7'b0000000) $display("FAIL memwait_ack: got ctl=%b want 0000000", ctl); else passes++;
        step();
        MemReqM = 0; MemAckM = 0;
        #1;
        total++;
        if (MemErr !== 1'b0) $display("FAIL memwait_err: got %b want 0", MemErr); else passes++;
        total++;
        if (StallCycles !== 16'd5) $display("FAIL memwait_count: got %0d want 5", StallCycles); else passes++;
        $display("mem_wait: err=%b sc=%0d", MemErr, StallCycles);
    endtask

    task automatic test_back_to_back();
        MemReqM = 1; MemAckM = 0;
        #1;
        total++;
        if (ctl !== 7'b1111100) $display("FAIL b2b_stall: got ctl=%b want 1111100", ctl); else passes++;
        step();
        MemAckM = 1;
        #1;
        total++;
        if (ctl !== 7'b0000000) $display("FAIL b2b_ack: got ctl=%b want 0000000", ctl); else passes++;
        step();
        // Still requesting and acked immediately: no stall, no state change.
        #1;
        total++;
        if (ctl !== 7'b0000000) $display("FAIL fast_ack: got ctl=%b want 0000000", ctl); else passes++;
        step();
        total++;
        if (StallCycles !== 16'd6) $display("FAIL b2b_count: got %0d want 6", StallCycles); else passes++;
        $display("back_to_back: sc=%0d", StallCycles);
        clear_inputs();
    endtask

    task automatic test_timeout();
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== 7'b1111100) $display("FAIL timeout_stall%0d: got ctl=%b want 1111100", i, ctl);
            else passes++;
            step();
        end
        #1;
        total++;
        if (ctl !== 7'b0000011) $display("FAIL timeout_release: got ctl=%b want 0000011", ctl); else passes++;
        total++;
        if (MemErr !== 1'b0) $display("FAIL timeout_err_early: got %b want 0", MemErr); else passes++;
        step();
        total++;
        if (MemErr !== 1'b1) $display("FAIL timeout_err: got %b want 1", MemErr); else passes++;
        clear_inputs();
        step();
        total++;
        if (MemErr !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", MemErr); else passes++;
        total++;
        if (StallCycles !== 16'd10) $display("FAIL timeout_count: got %0d want 10", StallCycles); else passes++;
        $display("timeout: err=%b sc=%0d", MemErr, StallCycles);
    endtask

    task automatic test_reset_mid_wait();
        MemReqM = 1;
        step();
        CLR_N = 1'b0;
        #1;
        total++;
        if (ctl !== 7'b0000000) $display("FAIL rst_mid_stalls: got ctl=%b want 0000000", ctl); else passes++;
        total++;
        if ({MemErr, StallCycles} !== '0) begin
            $display("FAIL rst_mid_state: got err=%b sc=%0d want 0/0", MemErr, StallCycles);
        end else passes++;
        step();
        CLR_N = 1'b1;
        #1;
        total++;
        if (ctl !== 7'b1111100) $display("FAIL rst_new_idle: got ctl=%b want 1111100", ctl); else passes++;
        step();
        total++;
        if (ctl !== 7'b1111100) $display("FAIL rst_new_wait: got ctl=%b want 1111100", ctl); else passes++;
        total++;
        if (StallCycles !== 16'd1) $display("FAIL rst_new_count: got %0d want 1", StallCycles); else passes++;
        MemAckM = 1;
        step();
        clear_inputs();
        $display("reset_mid_wait: err=%b sc=%0d", MemErr, StallCycles);
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
